// File: rtl/counterupdown_modn_1clk_sync_resetp_if.sv
// Control/status bundle for the mod-N up/down counter; clk and reset stay outside.
interface counterupdown_modn_1clk_sync_resetp_if #(
  parameter int n = 12
);
  logic         en;
  logic         up_down;
  logic         load;
  logic [n-1:0] load_value;
  logic         clr_flag;
  logic [n-1:0] q_counter;
  logic         tc;
  logic         ovf_flag;

  modport master (
    output en, up_down, load, load_value, clr_flag,
    input  q_counter, tc, ovf_flag
  );

  modport slave (
    input  en, up_down, load, load_value, clr_flag,
    output q_counter, tc, ovf_flag
  );
endinterface

// File: rtl/counterupdown_modn_1clk_sync_resetp.sv
// Mod-N up/down counter with step, clamped load, wrap/saturate mode,
// combinational terminal count and sticky boundary flag. Sync active-high reset.
module counterupdown_modn_1clk_sync_resetp #(
  parameter int n        = 12,
  parameter int MODULUS  = 4096,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic clk,
  input  logic rst_counter,
  counterupdown_modn_1clk_sync_resetp_if.slave bus
);
  localparam logic [n:0] P_MAX  = (n+1)'(MODULUS - 1);
  localparam logic [n:0] P_MOD  = (n+1)'(MODULUS);
  localparam logic [n:0] P_STEP = (n+1)'(STEP);

  logic [n-1:0] r_q;
  logic         r_ovf;

  logic [n:0]   w_q_ext;
  logic [n:0]   w_up_sum;
  logic [n:0]   w_ld_ext;
  logic [n-1:0] w_up_wrap;
  logic [n-1:0] w_dn_wrap;
  logic [n-1:0] w_ld;
  logic [n-1:0] w_nxt;
  logic         w_bnd_up;
  logic         w_bnd_dn;
  logic         w_bnd;
  logic         w_evt;

  // Boundary tests need n+1 bits so MODULUS = 2**n compares correctly; the
  // wrapped results always land below MODULUS, so n-bit modular math suffices.
  assign w_q_ext   = {1'b0, r_q};
  assign w_up_sum  = w_q_ext + P_STEP;
  assign w_bnd_up  = w_up_sum > P_MAX;
  assign w_bnd_dn  = w_q_ext < P_STEP;
  assign w_up_wrap = w_up_sum[n-1:0] - P_MOD[n-1:0];
  assign w_dn_wrap = r_q + P_MOD[n-1:0] - P_STEP[n-1:0];

  assign w_ld_ext  = {1'b0, bus.load_value};
  assign w_ld      = (w_ld_ext > P_MAX) ? P_MAX[n-1:0] : bus.load_value;

  assign w_bnd     = bus.up_down ? w_bnd_up : w_bnd_dn;
  assign w_evt     = bus.en & ~bus.load & ~rst_counter & w_bnd;

  always_comb begin
    w_nxt = r_q;
    if (bus.load) begin
      w_nxt = w_ld;
    end else if (bus.en) begin
      if (bus.up_down) begin
        if (!w_bnd_up)          w_nxt = w_up_sum[n-1:0];
        else if (SATURATE != 0) w_nxt = P_MAX[n-1:0];
        else                    w_nxt = w_up_wrap;
      end else begin
        if (!w_bnd_dn)          w_nxt = r_q - P_STEP[n-1:0];
        else if (SATURATE != 0) w_nxt = '0;
        else                    w_nxt = w_dn_wrap;
      end
    end
  end

  // A boundary event sets the flag even when clr_flag is asserted the same edge.
  always_ff @(posedge clk) begin
    if (rst_counter) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_q <= w_nxt;
      if (w_evt)             r_ovf <= 1'b1;
      else if (bus.clr_flag) r_ovf <= 1'b0;
    end
  end

  assign bus.q_counter = r_q;
  assign bus.tc        = w_evt;
  assign bus.ovf_flag  = r_ovf;
endmodule

// File: tb/tb_counterupdown_modn_1clk_sync_resetp.sv
// Three configurations (default wrap, mod-10 step-3 wrap, mod-10 step-3 saturate)
// share one stimulus stream and are compared against an arithmetic reference model.
module tb_counterupdown_modn_1clk_sync_resetp;
  logic        clk = 1'b0;
  logic        rst, en, ud, ld, clr;
  logic [11:0] lv;

  always #5 clk = ~clk;

  counterupdown_modn_1clk_sync_resetp_if #(.n(12)) b0 ();
  counterupdown_modn_1clk_sync_resetp_if #(.n(4))  b1 ();
  counterupdown_modn_1clk_sync_resetp_if #(.n(4))  b2 ();

  assign b0.en = en;  assign b0.up_down = ud;  assign b0.load = ld;
  assign b0.clr_flag = clr;  assign b0.load_value = lv;
  assign b1.en = en;  assign b1.up_down = ud;  assign b1.load = ld;
  assign b1.clr_flag = clr;  assign b1.load_value = lv[3:0];
  assign b2.en = en;  assign b2.up_down = ud;  assign b2.load = ld;
  assign b2.clr_flag = clr;  assign b2.load_value = lv[3:0];

  counterupdown_modn_1clk_sync_resetp #(.n(12), .MODULUS(4096), .STEP(1), .SATURATE(0))
    dut0 (.clk(clk), .rst_counter(rst), .bus(b0.slave));
  counterupdown_modn_1clk_sync_resetp #(.n(4), .MODULUS(10), .STEP(3), .SATURATE(0))
    dut1 (.clk(clk), .rst_counter(rst), .bus(b1.slave));
  counterupdown_modn_1clk_sync_resetp #(.n(4), .MODULUS(10), .STEP(3), .SATURATE(1))
    dut2 (.clk(clk), .rst_counter(rst), .bus(b2.slave));

  logic [31:0] w_q[3], w_tc[3], w_ov[3];
  assign w_q[0] = 32'(b0.q_counter);  assign w_tc[0] = 32'(b0.tc);  assign w_ov[0] = 32'(b0.ovf_flag);
  assign w_q[1] = 32'(b1.q_counter);  assign w_tc[1] = 32'(b1.tc);  assign w_ov[1] = 32'(b1.ovf_flag);
  assign w_q[2] = 32'(b2.q_counter);  assign w_tc[2] = 32'(b2.tc);  assign w_ov[2] = 32'(b2.ovf_flag);

  int errs   = 0;
  int checks = 0;
  int md[3]  = '{4096, 10, 10};
  int st[3]  = '{1, 3, 3};
  int sa[3]  = '{0, 0, 1};
  int mq[3]  = '{0, 0, 0};
  int mo[3]  = '{0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the range rules.
  function automatic void mdl(input int i, output int nq, output int no, output int t);
    int m   = md[i];
    int s   = st[i];
    int q   = mq[i];
    int lvv = (i == 0) ? int'(lv) : int'(lv[3:0]);
    bit b   = 1'b0;
    if (rst) begin
      nq = 0; no = 0; t = 0;
    end else begin
      nq = q;
      no = clr ? 0 : mo[i];
      if (ld) begin
        nq = (lvv > m - 1) ? m - 1 : lvv;
      end else if (en) begin
        if (ud) begin
          b  = (q + s > m - 1);
          nq = !b ? q + s : (sa[i] != 0) ? m - 1 : q + s - m;
        end else begin
          b  = (q < s);
          nq = !b ? q - s : (sa[i] != 0) ? 0 : q + m - s;
        end
      end
      if (b) no = 1;
      t = int'(b);
    end
  endfunction

  // Called at negedge with inputs already applied; checks tc, clocks, checks state.
  task automatic step();
    int nq[3], no[3], t[3];
    #1;
    for (int i = 0; i < 3; i++) begin
      mdl(i, nq[i], no[i], t[i]);
      chk($sformatf("tc%0d", i), w_tc[i], t[i]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      mq[i] = nq[i];
      mo[i] = no[i];
      chk($sformatf("q%0d", i), w_q[i], mq[i]);
      chk($sformatf("ovf%0d", i), w_ov[i], mo[i]);
    end
    @(negedge clk);
  endtask

  int e_up1[4]  = '{1, 4, 7, 0};
  int t_up1[4]  = '{1, 0, 0, 1};
  int e_dn1[4]  = '{8, 5, 2, 9};
  int t_dn1[4]  = '{1, 0, 0, 1};

  initial begin
    rst = 1'b1; en = 1'b1; ud = 1'b1; ld = 1'b0; clr = 1'b0; lv = '0;
    @(negedge clk);

    // reset, then count from zero
    step(); step();
    chk("rst_q", w_q[0], 0);
    chk("rst_ovf", w_ov[0], 0);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("count_up", w_q[0], k);
    end
    rst = 1'b1;
    #2 chk("sync_rst_not_async", w_q[0], 5);
    step();
    chk("sync_rst_q", w_q[0], 0);
    rst = 1'b0;

    // wrap up (dut1) / saturate up (dut2) from 8
    en = 1'b0; ld = 1'b1; lv = 12'd8;
    step();
    ld = 1'b0; en = 1'b1; ud = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("wrap_up_tc", w_tc[1], t_up1[k]);
      chk("sat_up_tc", w_tc[2], 1);
      step();
      chk("wrap_up_q", w_q[1], e_up1[k]);
      chk("sat_up_q", w_q[2], 9);
    end
    chk("wrap_up_ovf", w_ov[1], 1);

    // wrap down from 1
    en = 1'b0; ld = 1'b1; lv = 12'd1;
    step();
    ld = 1'b0; en = 1'b1; ud = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("wrap_dn_tc", w_tc[1], t_dn1[k]);
      step();
      chk("wrap_dn_q", w_q[1], e_dn1[k]);
    end

    // saturate down from 2
    en = 1'b0; ld = 1'b1; lv = 12'd2;
    step();
    ld = 1'b0; en = 1'b1; ud = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1 chk("sat_dn_tc", w_tc[2], 1);
      step();
      chk("sat_dn_q", w_q[2], 0);
    end

    // load clamp and priority over en, then reset over load
    ld = 1'b1; lv = 12'd15; en = 1'b1; ud = 1'b1;
    #1 chk("load_tc", w_tc[1], 0);
    step();
    chk("load_clamp", w_q[1], 9);
    chk("load_noclamp", w_q[0], 15);
    rst = 1'b1;
    step();
    chk("rst_over_load", w_q[1], 0);
    rst = 1'b0;

    // flag set wins over clear; clear on a quiet edge
    en = 1'b0; ld = 1'b1; lv = 12'd8;
    step();
    ld = 1'b0; en = 1'b1; ud = 1'b1; clr = 1'b1;
    step();
    chk("clr_race_ovf", w_ov[1], 1);
    step();
    chk("clr_ovf", w_ov[1], 0);
    clr = 1'b0;

    for (int k = 0; k < 400; k++) begin
      rst = ($urandom % 40) == 0;
      ld  = ($urandom % 8) == 0;
      en  = ($urandom % 4) != 0;
      ud  = $urandom % 2;
      clr = ($urandom % 6) == 0;
      lv  = 12'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
